// File: rtl/axi_rd_slave.sv
// AXI read slave: one burst at a time, one memory fetch per beat, RVALID two cycles after each AR/R handshake.
// Memory data arrives the cycle after mem_ren and is held in rdata_q for the rest of the beat.
module axi_rd_slave #(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter logic [63:0] MEM_BYTES = 64'h0800_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  ARID,
  input  logic [63:0] ARADDR,
  input  logic [7:0]  ARLEN,
  input  logic [2:0]  ARSIZE,
  input  logic [1:0]  ARBURST,
  input  logic [2:0]  ARPORT,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [3:0]  RID,
  output logic [63:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RLAST,
  output logic        RVALID,
  input  logic        RREADY,
  output logic        mem_ren,
  output logic [63:0] mem_raddr,
  input  logic [63:0] mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [1:0]  state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [7:0]  beat_q, beat_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic [3:0]  id_q, id_d;
  logic        err_q, err_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rlast_q, rlast_d;
  logic [63:0] rdata_q, rdata_d;
  logic        first_q, first_d;
  logic        ready_q;

  logic        ar_hs, r_hs, in_win, burst_bad;
  logic [63:0] inc, wmask, addr_nxt, rdata_now;
  logic        unused_prot;

  assign unused_prot = ^ARPORT;

  assign ar_hs = ARVALID && ARREADY;
  assign r_hs  = RVALID && RREADY;

  // Subtract before comparing so a window ending at the top of the address space cannot overflow.
  assign in_win = (addr_q >= BASE_ADDR) && ((addr_q - BASE_ADDR) < MEM_BYTES);

  assign burst_bad = (ARSIZE > 3'd3) || (ARBURST == 2'b11) ||
                     ((ARBURST == 2'b10) &&
                      !((ARLEN == 8'd1) || (ARLEN == 8'd3) || (ARLEN == 8'd7) || (ARLEN == 8'd15)));

  assign inc   = 64'd1 << size_q;
  assign wmask = ((64'(len_q) + 64'd1) << size_q) - 64'd1;

  always_comb begin
    addr_nxt = addr_q;
    case (burst_q)
      2'b01:   addr_nxt = addr_q + inc;
      2'b10:   addr_nxt = (addr_q & ~wmask) | ((addr_q + inc) & wmask);
      default: addr_nxt = addr_q;
    endcase
  end

  assign rdata_now = (rresp_q == RESP_OKAY) ? mem_rdata : 64'd0;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    id_d    = id_q;
    err_d   = err_q;
    rresp_d = rresp_q;
    rlast_d = rlast_q;
    first_d = 1'b0;
    rdata_d = first_q ? rdata_now : rdata_q;
    case (state_q)
      S_IDLE: begin
        if (ar_hs) begin
          id_d    = ARID;
          addr_d  = ARADDR;
          len_d   = ARLEN;
          size_d  = ARSIZE;
          burst_d = ARBURST;
          beat_d  = 8'd0;
          err_d   = burst_bad;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        rresp_d = err_q ? RESP_SLVERR : (in_win ? RESP_OKAY : RESP_DECERR);
        rlast_d = (beat_q == len_q);
        first_d = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (r_hs) begin
          if (rlast_q) begin
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_nxt;
            beat_d  = beat_q + 8'd1;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      addr_q  <= 64'd0;
      beat_q  <= 8'd0;
      len_q   <= 8'd0;
      size_q  <= 3'd0;
      burst_q <= 2'd0;
      id_q    <= 4'd0;
      err_q   <= 1'b0;
      rresp_q <= RESP_OKAY;
      rlast_q <= 1'b0;
      rdata_q <= 64'd0;
      first_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      id_q    <= id_d;
      err_q   <= err_d;
      rresp_q <= rresp_d;
      rlast_q <= rlast_d;
      rdata_q <= rdata_d;
      first_q <= first_d;
      ready_q <= 1'b1;
    end
  end

  // ready_q keeps ARREADY low until the first clock edge after reset release.
  assign ARREADY   = (state_q == S_IDLE) && ready_q;
  assign RVALID    = (state_q == S_RESP);
  assign RID       = id_q;
  assign RRESP     = rresp_q;
  assign RLAST     = rlast_q;
  assign RDATA     = first_q ? rdata_now : rdata_q;
  assign mem_ren   = (state_q == S_FETCH) && !err_q && in_win;
  assign mem_raddr = {addr_q[63:3], 3'b000};

endmodule
